z80_refresh_unit: RTL and testbench
===================================

Name: z80_refresh_unit

Overview:
- Owns the Z80 I and R registers and sequences the DRAM refresh window that follows every opcode fetch.
- Generalised successor of the single-instruction LD R,A handling: configurable counting width and refresh length.
- Supports concurrent LD R,A / LD I,A writes, and drives the refresh address bus {I,R}.
- Sits beside the M-cycle sequencer; the core's Z80FI wrapper reads reg_r/reg_i for formal comparison.

Parameters:
- R_CNT_WIDTH, 7: low bits of R that increment; upper bits hold (range 1..8).
- RFSH_TCYCLES, 2: T-states per refresh window (range 1..4).
- RESET_I, 8'h00: reset value of I.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high
- m1_fetch_done  input  1  one-cycle pulse at the end of opcode-fetch T2 (every M1, including prefix bytes and HALT NOP fetches)
- ld_r_we  input  1  write ld_data into R this cycle (LD R,A)
- ld_i_we  input  1  write ld_data into I this cycle (LD I,A)
- ld_data  input  8  value of A
- rfsh_active  output  1  high during every refresh T-state
- rfsh_last  output  1  high on the final refresh T-state
- rfsh_addr  output  16  {reg_i, reg_r}; valid while rfsh_active
- reg_r  output  8  current R
- reg_i  output  8  current I

Behaviour:
- Reset values: reg_r=0, reg_i=RESET_I, state IDLE, tcnt=0, rfsh_active=0, rfsh_last=0. All outputs are registered or decoded from state only.
- FSM states: IDLE, RFSH.
  - IDLE and m1_fetch_done: go to RFSH, tcnt=0.
  - RFSH: tcnt increments each cycle.
  - RFSH and tcnt==RFSH_TCYCLES-1: go to IDLE, and R increments on that edge.
- rfsh_active = (state==RFSH). rfsh_last = (state==RFSH && tcnt==RFSH_TCYCLES-1).
- rfsh_addr holds the pre-increment R throughout the window.
- Increment rule: R[R_CNT_WIDTH-1:0] += 1, modulo 2^R_CNT_WIDTH. R[7:R_CNT_WIDTH] is unchanged.
  - 8'h7F -> 8'h00; 8'hFF -> 8'h80 (default width).
- Write priority: ld_r_we in the same cycle as the increment edge means R = ld_data exactly; the increment is discarded.
- ld_i_we updates I on the next edge. If it lands mid-window, rfsh_addr changes from the following cycle.
- m1_fetch_done while in RFSH is ignored. No restart and no extra increment.
  - With the optional feature on, this case sets a sticky fault instead.
- Reset mid-window: next cycle is IDLE, rfsh_active=0, no increment; R and I return to their reset values.
- Latency: fetch pulse at cycle N gives rfsh_active on cycles N+1..N+RFSH_TCYCLES. The new R is visible at cycle N+RFSH_TCYCLES+1.
- Back-to-back M1s: m1_fetch_done in the cycle after rfsh_last is accepted normally.

Optional Feature:
- Macro: Z80_RFSH_AUDIT_EN.
- Defined: adds output ports rfsh_count[31:0] and rfsh_fault.
  - rfsh_count: completed refresh windows, wraps at 2^32.
  - rfsh_fault: sticky, set by m1_fetch_done while in RFSH; cleared only by reset.
  - Both reset to 0.
  - Adds immediate assertions: rfsh_active implies state==RFSH; tcnt < RFSH_TCYCLES; R upper bits change only via ld_r_we.
- Undefined: ports and assertions absent; behaviour otherwise identical.

Decomposition:
- Package z80_rfsh_pkg holds:
  - the rfsh_state_t enum {IDLE, RFSH};
  - localparam TCNT_W = 2;
  - function r_inc(r, cnt_width) for the masked increment, shared with the Z80FI spec modules for LD A,R / LD R,A checking.
- No sub-module is needed; the FSM and registers stay flat in one module.

Test Plan:
- Reset, then fetch pulse with R=0x00 -> rfsh_active two cycles with rfsh_addr=0x0000; reg_r=0x01 on the following cycle.
- ld_r_we with ld_data=0xFF, then one fetch -> reg_r=0x80 (bit 7 kept, low 7 wrap). With R_CNT_WIDTH=8 -> 0x00.
- ld_r_we with ld_data=0x42 on the increment edge -> reg_r=0x42 exactly, no 0x43.
- ld_i_we with 0x3F, R=0x10, then fetch -> rfsh_addr=0x3F10 during window; RFSH_TCYCLES=3 gives a 3-cycle window.
- Fetch pulse in the middle of the window -> ignored, single increment; with Z80_RFSH_AUDIT_EN, rfsh_fault=1 and rfsh_count=1.
- Reset asserted on the first refresh T-state with R=0x55 -> next cycle rfsh_active=0, reg_r=0x00, no increment.

Source files
------------

// File: rtl/z80_rfsh_pkg.sv
// Shared types and helpers for the Z80 refresh unit and the Z80FI R-register checkers.
`default_nettype none

package z80_rfsh_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RFSH = 1'b1
  } rfsh_state_t;

  localparam int TCNT_W = 2;

  // Increment the low cnt_width bits of R with wrap; the bits above them hold.
  function automatic logic [7:0] r_inc(input logic [7:0] r, input int cnt_width);
    logic [7:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < cnt_width) mask[b] = 1'b1;
    end
    return (r & ~mask) | ((r + 8'h01) & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/z80_refresh_unit.sv
// ============================================================================
// Module  : z80_refresh_unit
// Brief   : Z80 I/R register owner and post-M1 DRAM refresh window sequencer.
//           Optional audit counters/fault and checks under Z80_RFSH_AUDIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_refresh_unit
  import z80_rfsh_pkg::*;
#(
  parameter int          R_CNT_WIDTH  = 7,
  parameter int          RFSH_TCYCLES = 2,
  parameter logic [7:0]  RESET_I      = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_fetch_done,
  input  logic        ld_r_we,
  input  logic        ld_i_we,
  input  logic [7:0]  ld_data,
  output logic        rfsh_active,
  output logic        rfsh_last,
  output logic [15:0] rfsh_addr,
  output logic [7:0]  reg_r,
  output logic [7:0]  reg_i
`ifdef Z80_RFSH_AUDIT_EN
  ,
  output logic [31:0] rfsh_count,
  output logic        rfsh_fault
`endif
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(RFSH_TCYCLES - 1);

  rfsh_state_t       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]        reg_r_q, reg_r_d;
  logic [7:0]        reg_i_q, reg_i_d;
  logic              window_done;

  assign window_done = (state_q == RFSH) && (tcnt_q == TCNT_LAST);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    reg_r_d = reg_r_q;
    reg_i_d = reg_i_q;
    case (state_q)
      IDLE: begin
        if (m1_fetch_done) begin
          state_d = RFSH;
          tcnt_d  = '0;
        end
      end
      RFSH: begin
        if (window_done) begin
          state_d = IDLE;
          tcnt_d  = '0;
          reg_r_d = r_inc(reg_r_q, R_CNT_WIDTH);
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
    // An explicit LD R,A overrides the increment landing on the same edge.
    if (ld_r_we) reg_r_d = ld_data;
    if (ld_i_we) reg_i_d = ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      reg_r_q <= 8'h00;
      reg_i_q <= RESET_I;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      reg_r_q <= reg_r_d;
      reg_i_q <= reg_i_d;
    end
  end

  assign rfsh_active = (state_q == RFSH);
  assign rfsh_last   = window_done;
  assign rfsh_addr   = {reg_i_q, reg_r_q};
  assign reg_r       = reg_r_q;
  assign reg_i       = reg_i_q;

`ifdef Z80_RFSH_AUDIT_EN
  // Bits of R that only an explicit load may change.
  localparam logic [7:0] R_HOLD_MASK = r_inc(8'hFF, R_CNT_WIDTH);

  logic [31:0] rfsh_count_q, rfsh_count_d;
  logic        rfsh_fault_q, rfsh_fault_d;

  always_comb begin
    rfsh_count_d = rfsh_count_q;
    rfsh_fault_d = rfsh_fault_q;
    if (window_done) rfsh_count_d = rfsh_count_q + 32'd1;
    if (m1_fetch_done && (state_q == RFSH)) rfsh_fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rfsh_count_q <= '0;
      rfsh_fault_q <= 1'b0;
    end else begin
      rfsh_count_q <= rfsh_count_d;
      rfsh_fault_q <= rfsh_fault_d;
      assert (!rfsh_active || (state_q == RFSH));
      assert (int'(tcnt_q) < RFSH_TCYCLES);
      if (!ld_r_we) assert ((reg_r_d & R_HOLD_MASK) == (reg_r_q & R_HOLD_MASK));
    end
  end

  assign rfsh_count = rfsh_count_q;
  assign rfsh_fault = rfsh_fault_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_z80_refresh_unit.sv
// Bench for z80_refresh_unit: two configurations driven in lockstep, checked
// against a cycle-numbered window model plus hand-computed literal expectations.
`default_nettype none

module tb_z80_refresh_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m1_fetch_done = 1'b0;
  logic       ld_r_we = 1'b0;
  logic       ld_i_we = 1'b0;
  logic [7:0] ld_data = 8'h00;

  logic        act0, last0, act1, last1;
  logic [15:0] addr0, addr1;
  logic [7:0]  r0, i0, r1, i1;
`ifdef Z80_RFSH_AUDIT_EN
  logic [31:0] cnt0, cnt1;
  logic        flt0, flt1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  z80_refresh_unit u_d0 (
    .clk(clk), .reset(reset), .m1_fetch_done(m1_fetch_done),
    .ld_r_we(ld_r_we), .ld_i_we(ld_i_we), .ld_data(ld_data),
    .rfsh_active(act0), .rfsh_last(last0), .rfsh_addr(addr0),
    .reg_r(r0), .reg_i(i0)
`ifdef Z80_RFSH_AUDIT_EN
    , .rfsh_count(cnt0), .rfsh_fault(flt0)
`endif
  );

  z80_refresh_unit #(.R_CNT_WIDTH(8), .RFSH_TCYCLES(3), .RESET_I(8'hA5)) u_d1 (
    .clk(clk), .reset(reset), .m1_fetch_done(m1_fetch_done),
    .ld_r_we(ld_r_we), .ld_i_we(ld_i_we), .ld_data(ld_data),
    .rfsh_active(act1), .rfsh_last(last1), .rfsh_addr(addr1),
    .reg_r(r1), .reg_i(i1)
`ifdef Z80_RFSH_AUDIT_EN
    , .rfsh_count(cnt1), .rfsh_fault(flt1)
`endif
  );

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Model: a window is the set of cycle numbers start+1 .. start+T after an
  // accepted fetch in cycle start; R gains one in its low W bits when it closes.
  int         p_t[2]  = '{2, 3};
  int         p_w[2]  = '{7, 8};
  logic [7:0] p_ri[2] = '{8'h00, 8'hA5};
  int         m_start[2];
  logic [7:0] m_r[2], m_i[2];
  int         m_cnt[2];
  logic       m_flt[2];
  int         cyc = 0;
  bit         started = 0;

  function automatic logic [7:0] m_inc(input logic [7:0] r, input int w);
    int m, low;
    m   = 1 << w;
    low = int'(r) % m;
    return 8'(int'(r) - low + (low + 1) % m);
  endfunction

  function automatic bit in_win(input int k, input int c);
    return (m_start[k] >= 0) && (c >= m_start[k] + 1) && (c <= m_start[k] + p_t[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_r[k] = 8'h00; m_i[k] = p_ri[k]; m_start[k] = -1; m_cnt[k] = 0; m_flt[k] = 1'b0;
      end else begin
        bit busy, closing;
        busy    = in_win(k, cyc);
        closing = busy && (cyc == m_start[k] + p_t[k]);
        if (closing) begin m_r[k] = m_inc(m_r[k], p_w[k]); m_cnt[k]++; end
        if (ld_r_we) m_r[k] = ld_data;
        if (ld_i_we) m_i[k] = ld_data;
        if (m1_fetch_done && busy) m_flt[k] = 1'b1;
        if (m1_fetch_done && !busy) m_start[k] = cyc;
      end
    end
    if (reset) started = 1;
    cyc++;
  end

  task automatic check_inst(input int k, input logic a, input logic l, input logic [15:0] ad,
                            input logic [7:0] r, input logic [7:0] i);
    bit ea;
    ea = in_win(k, cyc);
    cmp($sformatf("d%0d rfsh_active", k), 32'(a), 32'(ea));
    cmp($sformatf("d%0d rfsh_last", k), 32'(l), 32'(ea && (cyc == m_start[k] + p_t[k])));
    cmp($sformatf("d%0d reg_r", k), 32'(r), 32'(m_r[k]));
    cmp($sformatf("d%0d reg_i", k), 32'(i), 32'(m_i[k]));
    if (ea) cmp($sformatf("d%0d rfsh_addr", k), 32'(ad), 32'({m_i[k], m_r[k]}));
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_inst(0, act0, last0, addr0, r0, i0);
      check_inst(1, act1, last1, addr1, r1, i1);
`ifdef Z80_RFSH_AUDIT_EN
      cmp("d0 rfsh_count", cnt0, 32'(m_cnt[0]));
      cmp("d1 rfsh_count", cnt1, 32'(m_cnt[1]));
      cmp("d0 rfsh_fault", 32'(flt0), 32'(m_flt[0]));
      cmp("d1 rfsh_fault", 32'(flt1), 32'(m_flt[1]));
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    cycle();
    cmp("lit reset r0", 32'(r0), 32'h00);
    cmp("lit reset i1", 32'(i1), 32'hA5);
    cmp("lit reset act0", 32'(act0), 32'h0);

    // First fetch with R=0
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    cmp("lit fetch1 act0", 32'(act0), 32'h1);
    cmp("lit fetch1 addr0", 32'(addr0), 32'h0000);
    cycle();
    cmp("lit fetch1 last0", 32'(last0), 32'h1);
    cycle();
    cmp("lit fetch1 r0", 32'(r0), 32'h01);
    cmp("lit fetch1 act0 off", 32'(act0), 32'h0);
    cmp("lit fetch1 last1", 32'(last1), 32'h1);
    cycle();
    cmp("lit fetch1 r1", 32'(r1), 32'h01);
    idle(2);

    // Wrap of the counting bits from 0xFF
    ld_r_we = 1'b1; ld_data = 8'hFF; cycle(); ld_r_we = 1'b0;
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    idle(5);
    cmp("lit wrap r0", 32'(r0), 32'h80);
    cmp("lit wrap r1", 32'(r1), 32'h00);

    // LD R,A on d0's increment edge
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    cycle();
    ld_r_we = 1'b1; ld_data = 8'h42; cycle(); ld_r_we = 1'b0;
    cmp("lit ldr prio r0", 32'(r0), 32'h42);
    cycle();
    cmp("lit ldr early r1", 32'(r1), 32'h43);
    idle(3);

    // I=0x3F, R=0x10 refresh address
    ld_i_we = 1'b1; ld_data = 8'h3F; cycle(); ld_i_we = 1'b0;
    ld_r_we = 1'b1; ld_data = 8'h10; cycle(); ld_r_we = 1'b0;
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    cmp("lit addr0 t1", 32'(addr0), 32'h3F10);
    cmp("lit addr1 t1", 32'(addr1), 32'h3F10);
    cycle();
    cmp("lit addr0 t2", 32'(addr0), 32'h3F10);
    cycle();
    cmp("lit win3 act1", 32'(act1), 32'h1);
    cmp("lit win3 last1", 32'(last1), 32'h1);
    cmp("lit win3 r0", 32'(r0), 32'h11);
    idle(3);

    // Fetch pulse mid-window is ignored
    m1_fetch_done = 1'b1; cycle(); cycle(); m1_fetch_done = 1'b0;
    idle(5);
    cmp("lit midwin r0", 32'(r0), 32'h12);
    cmp("lit midwin r1", 32'(r1), 32'h12);
`ifdef Z80_RFSH_AUDIT_EN
    cmp("lit midwin fault0", 32'(flt0), 32'h1);
`endif

    // Reset on the first refresh T-state with R=0x55
    ld_r_we = 1'b1; ld_data = 8'h55; cycle(); ld_r_we = 1'b0;
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    cmp("lit rst act0", 32'(act0), 32'h0);
    cmp("lit rst r0", 32'(r0), 32'h00);
    cmp("lit rst r1", 32'(r1), 32'h00);
    cmp("lit rst i1", 32'(i1), 32'hA5);
    idle(3);

    // LD I,A mid-window, then back-to-back fetch after rfsh_last
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    ld_i_we = 1'b1; ld_data = 8'h77; cycle(); ld_i_we = 1'b0;
    cmp("lit ldi mid addr0", 32'(addr0), 32'h7700);
    cmp("lit ldi mid last0", 32'(last0), 32'h1);
    cycle();
    cmp("lit b2b r0", 32'(r0), 32'h01);
    m1_fetch_done = 1'b1; cycle(); m1_fetch_done = 1'b0;
    cmp("lit b2b act0", 32'(act0), 32'h1);
    cmp("lit b2b addr0", 32'(addr0), 32'h7701);
    idle(5);
    cmp("lit b2b r0 end", 32'(r0), 32'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
